// File: rtl/mem_write_buffer_if.sv
// ============================================================================
// Module  : mem_write_buffer_if
// Brief   : CPU-side and RAM-side signal bundle of the posted-write buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]        cpu_addr;
  logic [DATA_W-1:0]        cpu_wdata;
  logic                     cpu_we;
  logic                     cpu_re;
  logic [DATA_W-1:0]        cpu_rdata;
  logic                     cpu_stall;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_we;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic [$clog2(DEPTH):0]   buf_count;
  logic                     empty;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
    output cpu_rdata, cpu_stall, mem_addr, mem_we, mem_wdata, buf_count, empty
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_addr, mem_we, mem_wdata, buf_count, empty
  );
endinterface

`default_nettype wire

// File: rtl/mem_write_buffer.sv
// ============================================================================
// Module  : mem_write_buffer
// Brief   : Posted-write FIFO in front of a word RAM; loads win the port and
//           forward from buffered stores. Option macro: WB_COALESCE_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  mem_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_newest;
  logic [PTR_W-1:0]  w_idx;
  logic              w_pop;
  logic              w_full;
  logic              w_stall;
  logic              w_coal;
  logic              w_push;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_newest = r_tail - PTR_W'(1);
  assign w_pop    = (r_count != '0) && !bus.cpu_re;
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_stall  = bus.cpu_we && (bus.cpu_re || (w_full && !w_pop));

`ifdef WB_COALESCE_EN
  // The newest entry is only safe to rewrite when it is not the one leaving.
  assign w_coal = bus.cpu_we && !w_stall && (r_count != '0)
                  && (r_addr[w_newest] == bus.cpu_addr)
                  && !(w_pop && (r_count == CNT_W'(1)));
`else
  assign w_coal = 1'b0;
`endif

  assign w_push = bus.cpu_we && !w_stall && !w_coal;

  // Scan oldest to newest so the last hit is the most recent store.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == bus.cpu_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  assign bus.cpu_rdata = w_fwd_hit ? w_fwd_data : bus.mem_rdata;
  assign bus.cpu_stall = w_stall;
  assign bus.mem_we    = w_pop;
  assign bus.mem_addr  = (!bus.cpu_re && (r_count != '0)) ? r_addr[r_head] : bus.cpu_addr;
  assign bus.mem_wdata = r_data[r_head];
  assign bus.buf_count = r_count;
  assign bus.empty     = (r_count == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Entry payload carries no reset; validity comes from head/count alone.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.cpu_addr;
      r_data[r_tail] <= bus.cpu_wdata;
    end else if (w_coal) begin
      r_data[w_newest] <= bus.cpu_wdata;
    end
  end
endmodule

`default_nettype wire
